// File: rtl/radix_bist_controller.sv
// rtl/radix_bist_controller.sv - BIST operand mux, pattern LFSR and MISR signature controller for the radix-4 multiplier
module radix_bist_controller #(
  parameter int          WIDTH     = 8,
  parameter int          PATTERNS  = 256,
  parameter logic [63:0] LFSR_POLY = 64'hB400,
  parameter logic [63:0] LFSR_SEED = 64'hACE1,
  parameter logic [63:0] MISR_POLY = 64'h1021,
  parameter logic [63:0] GOLDEN    = 64'h0000,
  parameter int          TIMEOUT   = 64
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_test_en,
  input  logic [WIDTH-1:0]                 i_user_x,
  input  logic [WIDTH-1:0]                 i_user_y,
  input  logic                             i_user_start,
  output logic [WIDTH-1:0]                 o_dut_x,
  output logic [WIDTH-1:0]                 o_dut_y,
  output logic                             o_dut_start,
  input  logic [2*WIDTH-1:0]               i_dut_result,
  input  logic                             i_dut_ready,
  output logic [2*WIDTH-1:0]               o_result,
  output logic                             o_ready,
  output logic                             o_bist_busy,
  output logic                             o_bist_done,
  output logic                             o_bist_pass,
  output logic                             o_bist_timeout,
  output logic [2*WIDTH-1:0]               o_signature,
  output logic [$clog2(PATTERNS+1)-1:0]    o_pattern_count
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(PATTERNS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [W2-1:0] LPOLY = W2'(LFSR_POLY);
  localparam logic [W2-1:0] MPOLY = W2'(MISR_POLY);
  localparam logic [W2-1:0] GOLD  = W2'(GOLDEN);
  // An all-zero seed would lock the Galois LFSR at zero forever.
  localparam logic [W2-1:0] SEED  = (W2'(LFSR_SEED) == '0) ? {{(W2-1){1'b0}}, 1'b1} : W2'(LFSR_SEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_COMPACT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W2-1:0]  r_lfsr;
  logic [W2-1:0]  r_misr;
  logic [CW-1:0]  r_count;
  logic [TW-1:0]  r_wait;
  logic           r_pass;
  logic           r_timeout;

  logic           w_load;
  logic           w_clr_wait;
  logic           w_inc_wait;
  logic           w_compact;
  logic           w_set_timeout;
  logic           w_eval;
  logic           w_idle;
  logic           w_last;
  logic           w_tmo_hit;
  logic [W2-1:0]  w_misr_next;
  logic [W2-1:0]  w_lfsr_next;
  logic [CW-1:0]  w_count_inc;

  assign w_misr_next = {r_misr[W2-2:0], 1'b0} ^ (r_misr[W2-1] ? MPOLY : '0) ^ i_dut_result;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LPOLY : '0);
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = (w_count_inc == CW'(PATTERNS));
  assign w_tmo_hit   = (r_wait == TW'(TIMEOUT - 1));

  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_clr_wait    = 1'b0;
    w_inc_wait    = 1'b0;
    w_compact     = 1'b0;
    w_set_timeout = 1'b0;
    w_eval        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_test_en) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = i_test_en ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        w_clr_wait = 1'b1;
        w_next     = i_test_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        w_inc_wait = 1'b1;
        // The first WAIT cycle still sees the multiplier's idle ready level.
        if (!i_test_en) begin
          w_next = S_IDLE;
        end else if ((r_wait != '0) && i_dut_ready) begin
          w_next = S_COMPACT;
        end else if (w_tmo_hit) begin
          w_set_timeout = 1'b1;
          w_next        = S_DONE;
        end
      end
      S_COMPACT: begin
        if (!i_test_en) begin
          w_next = S_IDLE;
        end else begin
          w_compact = 1'b1;
          w_eval    = w_last;
          w_next    = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        if (!i_test_en) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= SEED;
      r_misr    <= '0;
      r_count   <= '0;
      r_wait    <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_lfsr    <= SEED;
        r_misr    <= '0;
        r_count   <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_clr_wait) begin
        r_wait <= '0;
      end else if (w_inc_wait) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_compact) begin
        r_misr <= w_misr_next;
        r_lfsr <= w_lfsr_next;
        if (r_count != CW'(PATTERNS)) r_count <= w_count_inc;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
        r_pass    <= 1'b0;
      end
      if (w_eval) r_pass <= (w_misr_next == GOLD);
    end
  end

  assign w_idle          = (r_state == S_IDLE);
  assign o_dut_x         = w_idle ? i_user_x : r_lfsr[WIDTH-1:0];
  assign o_dut_y         = w_idle ? i_user_y : r_lfsr[W2-1:WIDTH];
  assign o_dut_start     = w_idle ? i_user_start : (r_state == S_ISSUE);
  assign o_result        = i_dut_result;
  assign o_ready         = w_idle & i_dut_ready;
  assign o_bist_busy     = (r_state == S_LOAD) || (r_state == S_ISSUE) ||
                           (r_state == S_WAIT) || (r_state == S_COMPACT);
  assign o_bist_done     = (r_state == S_DONE);
  assign o_bist_pass     = r_pass;
  assign o_bist_timeout  = r_timeout;
  assign o_signature     = r_misr;
  assign o_pattern_count = r_count;

endmodule

// File: doc/radix_bist_controller.md
# radix_bist_controller

Parametrised built-in self-test controller for the radix-4 multiplier. It muxes operands between the user port and an internal 2·WIDTH-bit Galois LFSR. In test mode it issues PATTERNS multiplications through a start/ready handshake and compacts every product into a MISR. At the end it compares the signature against a golden value and reports pass/fail, with a handshake timeout and abort support. It sits between the top-level user pins and the multiplier instance.

## Interface
- WIDTH, 8, operand width; products are 2·WIDTH bits
- PATTERNS, 256, number of test vectors per run (≥1)
- LFSR_POLY, 16'hB400, Galois feedback mask for the 2·WIDTH-bit pattern LFSR
- LFSR_SEED, 16'hACE1, LFSR load value at run start; 0 is replaced by 1
- MISR_POLY, 16'h1021, MISR feedback mask
- GOLDEN, 16'h0000, expected final signature
- TIMEOUT, 64, maximum cycles allowed in WAIT per pattern
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- test_en  in  1  level; high requests or holds a BIST run, low aborts or returns to user mode
- user_x, user_y  in  WIDTH  user operands
- user_start  in  1  user start pulse
- dut_x, dut_y  out  WIDTH  operands to the multiplier
- dut_start  out  1  start to the multiplier
- dut_result  in  2·WIDTH  multiplier product
- dut_ready  in  1  multiplier ready (low while busy, high when the product is valid)
- result  out  2·WIDTH  dut_result passed through unchanged
- ready  out  1  dut_ready in IDLE; 0 in every other state
- bist_busy  out  1  high in LOAD/ISSUE/WAIT/COMPACT
- bist_done  out  1  high in DONE
- bist_pass  out  1  run verdict, valid while bist_done is high
- bist_timeout  out  1  sticky flag: the last run hit TIMEOUT
- signature  out  2·WIDTH  current MISR value
- pattern_count  out  $clog2(PATTERNS+1)  number of patterns compacted so far

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, COMPACT, DONE.
- IDLE:
  - dut_x, dut_y and dut_start are combinational copies of user_x, user_y and user_start.
  - If test_en=1, go to LOAD.
- LOAD:
  - lfsr ← LFSR_SEED (or 1 if the seed is 0); misr ← 0; count ← 0; bist_pass ← 0; bist_timeout ← 0.
  - Go to ISSUE.
- Test mode (all states except IDLE):
  - dut_x = lfsr[WIDTH-1:0] and dut_y = lfsr[2·WIDTH-1:WIDTH], both registered.
  - user_start is ignored.
- ISSUE:
  - dut_start=1 for exactly one cycle.
  - Clear the WAIT cycle counter; go to WAIT.
- WAIT:
  - dut_ready is ignored in the first WAIT cycle, because the multiplier drops ready one cycle after start.
  - From the second WAIT cycle, dut_ready=1 moves to COMPACT.
  - If the WAIT counter reaches TIMEOUT: bist_timeout ← 1, bist_pass ← 0, go to DONE.
- COMPACT:
  - MISR update: misr ← (({misr[2W-2:0],1'b0}) ^ (misr[2W-1] ? MISR_POLY : 0)) ^ dut_result.
  - LFSR update: lfsr ← (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
  - count ← count+1.
  - If count+1 == PATTERNS, go to DONE; otherwise go to ISSUE.
- DONE:
  - On the entry cycle, if not timed out, bist_pass ← (misr_next == GOLDEN), using the final MISR value.
  - Stay in DONE while test_en=1.
  - test_en=0 returns to IDLE. bist_done drops; bist_pass, bist_timeout and signature hold until the next LOAD.
- Abort: test_en=0 in LOAD/ISSUE/WAIT/COMPACT goes to IDLE on the next edge. bist_pass=0 and no DONE is generated. The user mux takes effect in IDLE.
- Width rules:
  - LFSR and MISR are 2·WIDTH bits; polynomial and golden parameters are truncated or zero-extended to 2·WIDTH.
  - The count saturates at PATTERNS and never wraps.

## Timing
- Reset (reset_n=0, async) values:
  - state=IDLE, lfsr=LFSR_SEED, misr=0, count=0.
  - bist_busy=0, bist_done=0, bist_pass=0, bist_timeout=0.
  - dut_start follows user_start; ready follows dut_ready.
- Deasserting reset mid-run: the controller is in IDLE on the first edge after release and no dut_start pulse is emitted.
- Latency:
  - test_en rising to first dut_start: 2 cycles (IDLE→LOAD→ISSUE).
  - Per pattern: 1 (ISSUE) + N (WAIT, N ≥ 2 including the ignored cycle) + 1 (COMPACT).
- dut_x and dut_y are stable from ISSUE through COMPACT and change only after COMPACT.
- If dut_ready and the timeout expire in the same cycle, dut_ready wins.
- test_en dropping in the same cycle that COMPACT would go to DONE: the abort wins (go to IDLE).

## Test plan
- Reset: hold reset_n=0 for 3 cycles, then release. All flags are 0; with test_en=0, driving user_x=0x12, user_y=0x34, user_start=1 appears on dut_x/dut_y/dut_start in the same cycle.
- Pattern sequence: test_en=1 with a behavioural multiplier (3-cycle latency). The first dut_start carries x=0xE1, y=0xAC; the second carries x=0x70, y=0xE2.
- Pass run: PATTERNS=4, GOLDEN set to the MISR value the bench model computes over the four products. bist_done=1, bist_pass=1, pattern_count=4, exactly 4 dut_start pulses.
- Fail run: same as the pass run with GOLDEN off by one bit. bist_done=1, bist_pass=0, bist_timeout=0.
- Timeout: dut_ready stuck at 0, TIMEOUT=64. DONE is reached 64 WAIT cycles after the first start, with bist_timeout=1, bist_pass=0, pattern_count=0.
- Abort: drop test_en during the WAIT of pattern 2. The next cycle is IDLE, no further dut_start pulses, bist_done=0, user passthrough restored; raising test_en again restarts from x=0xE1.
